// File: rtl/control_double.sv
// control_double: Moore FSM sequencing a double-dabble binary-to-BCD converter.
// Issues the ld / ldr2 / sh / dec strobes to the datapath and raises done
// when the datapath reports that all bits have been shifted.
// Optional feature macro: CONTROL_DOUBLE_ASCII_EN. When it is defined,
// state_ascii shows the current state letter. When it is not defined,
// state_ascii is tied to 8'h00.
module control_double #(
   parameter int unsigned NDIG      = 4,
   parameter int unsigned DONE_HOLD = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            init,
   input  logic [NDIG-1:0] msb,
   input  logic            z,
   output logic            ld,
   output logic            sh,
   output logic            ldr2,
   output logic            dec,
   output logic            done,
   output logic [7:0]      state_ascii
);

   localparam int unsigned HOLD_W = (DONE_HOLD > 1) ? $clog2(DONE_HOLD) : 1;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      CHECK = 3'd2,
      ADD   = 3'd3,
      SHIFT = 3'd4,
      DEC   = 3'd5,
      TESTZ = 3'd6,
      DONE  = 3'd7
   } state_t;

   state_t              state, state_nxt;
   logic [HOLD_W-1:0]   hold_cnt, hold_cnt_nxt;
   logic                ld_nxt, sh_nxt, ldr2_nxt, dec_nxt, done_nxt;

   // State, hold counter and registered strobes (strobes decoded from next state)
   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= IDLE;
         hold_cnt <= '0;
         ld       <= 1'b0;
         sh       <= 1'b0;
         ldr2     <= 1'b0;
         dec      <= 1'b0;
         done     <= 1'b0;
      end else begin
         state    <= state_nxt;
         hold_cnt <= hold_cnt_nxt;
         ld       <= ld_nxt;
         sh       <= sh_nxt;
         ldr2     <= ldr2_nxt;
         dec      <= dec_nxt;
         done     <= done_nxt;
      end
   end

   // Next-state transitions, done hold count and one-hot strobe decode
   always_comb begin
      state_nxt    = IDLE;
      hold_cnt_nxt = '0;
      ld_nxt       = 1'b0;
      sh_nxt       = 1'b0;
      ldr2_nxt     = 1'b0;
      dec_nxt      = 1'b0;
      done_nxt     = 1'b0;

      case (state)
         IDLE:    state_nxt = init ? LOAD : IDLE;
         LOAD:    state_nxt = CHECK;
         CHECK:   state_nxt = (|msb) ? ADD : SHIFT;
         ADD:     state_nxt = SHIFT;
         SHIFT:   state_nxt = DEC;
         DEC:     state_nxt = TESTZ;
         TESTZ:   state_nxt = z ? DONE : CHECK;
         DONE: begin
            if (hold_cnt >= HOLD_W'(DONE_HOLD - 1)) begin
               state_nxt = IDLE;
            end else begin
               state_nxt    = DONE;
               hold_cnt_nxt = hold_cnt + HOLD_W'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase

      case (state_nxt)
         LOAD:    ld_nxt   = 1'b1;
         ADD:     ldr2_nxt = 1'b1;
         SHIFT:   sh_nxt   = 1'b1;
         DEC:     dec_nxt  = 1'b1;
         DONE:    done_nxt = 1'b1;
         default: ;
      endcase
   end

`ifdef CONTROL_DOUBLE_ASCII_EN
   logic [7:0] ascii_nxt;

   // Debug letter for the state being entered
   always_comb begin
      ascii_nxt = 8'h49;
      case (state_nxt)
         IDLE:    ascii_nxt = 8'h49;
         LOAD:    ascii_nxt = 8'h4C;
         CHECK:   ascii_nxt = 8'h43;
         ADD:     ascii_nxt = 8'h41;
         SHIFT:   ascii_nxt = 8'h53;
         DEC:     ascii_nxt = 8'h44;
         TESTZ:   ascii_nxt = 8'h54;
         DONE:    ascii_nxt = 8'h45;
         default: ascii_nxt = 8'h49;
      endcase
   end

   // Registered debug letter, 'I' out of reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_ascii <= 8'h49;
      end else begin
         state_ascii <= ascii_nxt;
      end
   end
`else
   assign state_ascii = 8'h00;
`endif

endmodule

// File: tb/tb_control_double.sv
// tb_control_double: directed sequence for control_double.
// Each check compares the strobes {ld,sh,ldr2,dec,done} and state_ascii
// against hand-derived values, sampled 1 time unit after the rising edge.
`timescale 1ns/1ps
module tb_control_double;

   logic       clk = 1'b0;
   logic       rst;
   logic       init;
   logic [3:0] msb;
   logic       z;
   logic       ld, sh, ldr2, dec, done;
   logic [7:0] state_ascii;

   int n_cmp = 0;
   int n_err = 0;

   localparam logic [4:0] S_NONE = 5'b00000;
   localparam logic [4:0] S_LD   = 5'b10000;
   localparam logic [4:0] S_SH   = 5'b01000;
   localparam logic [4:0] S_LDR2 = 5'b00100;
   localparam logic [4:0] S_DEC  = 5'b00010;
   localparam logic [4:0] S_DONE = 5'b00001;

   control_double #(.NDIG(4), .DONE_HOLD(1)) dut (
      .clk         (clk),
      .rst         (rst),
      .init        (init),
      .msb         (msb),
      .z           (z),
      .ld          (ld),
      .sh          (sh),
      .ldr2        (ldr2),
      .dec         (dec),
      .done        (done),
      .state_ascii (state_ascii)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [4:0] exp_s, input logic [7:0] letter);
      logic [4:0] got_s;
      logic [7:0] exp_a;
      got_s = {ld, sh, ldr2, dec, done};
`ifdef CONTROL_DOUBLE_ASCII_EN
      exp_a = letter;
`else
      exp_a = 8'h00;
`endif
      n_cmp++;
      assert (got_s === exp_s) else begin
         n_err++;
         $error("FAIL %s strobes got %b want %b", tag, got_s, exp_s);
      end
      n_cmp++;
      assert (state_ascii === exp_a) else begin
         n_err++;
         $error("FAIL %s ascii got %h want %h", tag, state_ascii, exp_a);
      end
   endtask

   initial begin
      rst  = 1'b0;
      init = 1'b0;
      msb  = 4'b0000;
      z    = 1'b0;

      // 1: reset for two edges, then released
      tick();
      tick();
      chk("rst_idle", S_NONE, "I");
      rst = 1'b1;
      tick();
      chk("post_rst_idle", S_NONE, "I");

      // 2: one-bit conversion, no add
      init = 1'b1; msb = 4'b0000; z = 1'b1;
      tick(); chk("t2_load", S_LD, "L");
      init = 1'b0;
      tick(); chk("t2_check", S_NONE, "C");
      tick(); chk("t2_shift", S_SH, "S");
      tick(); chk("t2_dec", S_DEC, "D");
      tick(); chk("t2_testz", S_NONE, "T");
      tick(); chk("t2_done", S_DONE, "E");
      tick(); chk("t2_idle", S_NONE, "I");
      tick(); chk("t2_idle2", S_NONE, "I");

      // 3: three bits, every bit needs an add
      init = 1'b1; msb = 4'b1000; z = 1'b0;
      tick(); chk("t3_load", S_LD, "L");
      init = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick(); chk("t3_check", S_NONE, "C");
         tick(); chk("t3_add", S_LDR2, "A");
         tick(); chk("t3_shift", S_SH, "S");
         tick(); chk("t3_dec", S_DEC, "D");
         tick(); chk("t3_testz", S_NONE, "T");
         z = (i == 2);
      end
      tick(); chk("t3_done", S_DONE, "E");
      z = 1'b0;
      tick(); chk("t3_idle", S_NONE, "I");

      // 4: z never set, loop persists without done
      init = 1'b1; msb = 4'b0100; z = 1'b0;
      tick(); chk("t4_load", S_LD, "L");
      init = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick(); chk("t4_check", S_NONE, "C");
         tick(); chk("t4_add", S_LDR2, "A");
         tick(); chk("t4_shift", S_SH, "S");
         tick(); chk("t4_dec", S_DEC, "D");
         tick(); chk("t4_testz", S_NONE, "T");
      end

      // 5: reset asserted while in SHIFT
      tick(); chk("t5_check", S_NONE, "C");
      tick(); chk("t5_add", S_LDR2, "A");
      tick(); chk("t5_shift", S_SH, "S");
      rst = 1'b0;
      tick(); chk("t5_rst_idle", S_NONE, "I");
      rst = 1'b1; msb = 4'b0000;
      tick(); chk("t5_idle", S_NONE, "I");
      tick(); chk("t5_idle2", S_NONE, "I");

      // 6: init ignored in SHIFT and DONE, held init restarts from IDLE
      init = 1'b1; msb = 4'b0000; z = 1'b0;
      tick(); chk("t6_load", S_LD, "L");
      init = 1'b0;
      tick(); chk("t6_check", S_NONE, "C");
      tick(); chk("t6_shift", S_SH, "S");
      init = 1'b1;
      tick(); chk("t6_dec", S_DEC, "D");
      init = 1'b0;
      tick(); chk("t6_testz", S_NONE, "T");
      z = 1'b1;
      tick(); chk("t6_done", S_DONE, "E");
      init = 1'b1;
      tick(); chk("t6_idle", S_NONE, "I");
      tick(); chk("t6_reload", S_LD, "L");
      init = 1'b0;
      tick(); chk("t6_check2", S_NONE, "C");
      tick(); chk("t6_shift2", S_SH, "S");
      tick(); chk("t6_dec2", S_DEC, "D");
      tick(); chk("t6_testz2", S_NONE, "T");
      tick(); chk("t6_done2", S_DONE, "E");
      tick(); chk("t6_idle2", S_NONE, "I");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
